// File: rtl/control_pkg.sv
// Shared constants and types for the MIPS main control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode encodings, ALU-op class codes, ctrl_word_t and CTRL_NOP.
package control_pkg;

   // MIPS-I opcode field encodings (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation class handed to the ALU-control stage
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Field order matches the port order of the top level
   typedef struct packed {
      logic       reg_dst;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       j;
   } ctrl_word_t;

   // NOP word: no register write, no memory access, no control transfer
   localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Opcode decoder: maps the 6-bit opcode to one ctrl_word_t.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode (in, 6) opcode field; ctrl_word (out, ctrl_word_t) decoded control word.
module control_decode
   import control_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_word_t ctrl_word
);

   always_comb begin
      ctrl_word = CTRL_NOP;
      // Unlisted opcodes (and X/Z in simulation) fall through to the NOP word.
      // Don't-care fields stay at 0 from the default above.
      case (opcode)
         OP_RTYPE: begin
            ctrl_word.reg_dst   = 1'b1;
            ctrl_word.alu_op    = ALU_FUNCT;
            ctrl_word.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl_word.mem_read   = 1'b1;
            ctrl_word.mem_to_reg = 1'b1;
            ctrl_word.alu_op     = ALU_ADD;
            ctrl_word.alu_src    = 1'b1;
            ctrl_word.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl_word.mem_write = 1'b1;
            ctrl_word.alu_op    = ALU_ADD;
            ctrl_word.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            ctrl_word.branch = 1'b1;
            ctrl_word.alu_op = ALU_SUB;
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl_word.alu_op    = ALU_ADD;
            ctrl_word.alu_src   = 1'b1;
            ctrl_word.reg_write = 1'b1;
         end
         OP_J: begin
            ctrl_word.j = 1'b1;
         end
         default: begin
            ctrl_word = CTRL_NOP;
         end
      endcase
   end

endmodule

// File: rtl/control.sv
// Main control unit: decodes the opcode into registered datapath steering signals.
// Latency: 1 cycle (opcode sampled at rising clk, word visible after that edge).
// Backpressure: none; a new opcode is decoded every cycle.
// Ports: clk, rst_n (async active-low, clears to NOP), c (opcode instr[31:26]);
//        outputs RegDst, Branch, MemRead, MemtoReg, Alu_op[1:0], MemWrite, AluSrc,
//        RegWrite, J -- the unpacked fields of the registered control word.
module control
   import control_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] c,
   output logic       RegDst,
   output logic       Branch,
   output logic       MemRead,
   output logic       MemtoReg,
   output logic [1:0] Alu_op,
   output logic       MemWrite,
   output logic       AluSrc,
   output logic       RegWrite,
   output logic       J
);

   ctrl_word_t dec_word;
   ctrl_word_t ctrl_d;
   ctrl_word_t ctrl_q;

   control_decode u_decode (
      .opcode    (c),
      .ctrl_word (dec_word)
   );

   always_comb begin
      ctrl_d = dec_word;
   end

   // Registering the word gives the datapath one glitch-free control word per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= CTRL_NOP;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign RegDst   = ctrl_q.reg_dst;
   assign Branch   = ctrl_q.branch;
   assign MemRead  = ctrl_q.mem_read;
   assign MemtoReg = ctrl_q.mem_to_reg;
   assign Alu_op   = ctrl_q.alu_op;
   assign MemWrite = ctrl_q.mem_write;
   assign AluSrc   = ctrl_q.alu_src;
   assign RegWrite = ctrl_q.reg_write;
   assign J        = ctrl_q.j;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the main control unit: decode table, random opcodes
// against a class-based reference model, latency and async-reset sequences.
module tb_control;

   logic       clk;
   logic       rst_n;
   logic [5:0] c;
   logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, AluSrc, RegWrite, J;
   logic [1:0] Alu_op;

   int tests_run = 0;
   int tests_failed = 0;

   // Observed word in the order: RegDst Branch MemRead MemtoReg Alu_op MemWrite AluSrc RegWrite J
   logic [9:0] act;
   assign act = {RegDst, Branch, MemRead, MemtoReg, Alu_op, MemWrite, AluSrc, RegWrite, J};

   control dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .c        (c),
      .RegDst   (RegDst),
      .Branch   (Branch),
      .MemRead  (MemRead),
      .MemtoReg (MemtoReg),
      .Alu_op   (Alu_op),
      .MemWrite (MemWrite),
      .AluSrc   (AluSrc),
      .RegWrite (RegWrite),
      .J        (J)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] c;
      logic [9:0] exp;
      string      name;
   } vec_t;

   // Reference model built from instruction classes rather than a field table
   function automatic logic [9:0] ref_word(input logic [5:0] op);
      bit is_r, is_lw, is_sw, is_beq, is_addi, is_j, uses_imm, writes_reg;
      logic [1:0] alu;
      is_r       = (op == 6'd0);
      is_lw      = (op == 6'd35);
      is_sw      = (op == 6'd43);
      is_beq     = (op == 6'd4);
      is_addi    = (op == 6'd8) || (op == 6'd9);
      is_j       = (op == 6'd2);
      uses_imm   = is_lw || is_sw || is_addi;
      writes_reg = is_r || is_lw || is_addi;
      alu        = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
      return {is_r, is_beq, is_lw, is_lw, alu, is_sw, uses_imm, writes_reg, is_j};
   endfunction

   task automatic check(input string name, input logic [9:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive opcode, take one rising edge, sample 1 time unit later
   task automatic step(input logic [5:0] op);
      c = op;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];
   logic [5:0] legal[7];

   initial begin
      vecs[0] = '{6'b000000, 10'b1_0_0_0_10_0_0_1_0, "rtype"};
      vecs[1] = '{6'b100011, 10'b0_0_1_1_00_0_1_1_0, "lw"};
      vecs[2] = '{6'b101011, 10'b0_0_0_0_00_1_1_0_0, "sw"};
      vecs[3] = '{6'b000100, 10'b0_1_0_0_01_0_0_0_0, "beq"};
      vecs[4] = '{6'b000000, 10'b1_0_0_0_10_0_0_1_0, "rtype2"};
      vecs[5] = '{6'b001001, 10'b0_0_0_0_00_0_1_1_0, "addiu"};
      vecs[6] = '{6'b001000, 10'b0_0_0_0_00_0_1_1_0, "addi"};
      vecs[7] = '{6'b000010, 10'b0_0_0_0_00_0_0_0_1, "j"};
      vecs[8] = '{6'b111111, 10'b0_0_0_0_00_0_0_0_0, "illegal_3f"};
      vecs[9] = '{6'b000011, 10'b0_0_0_0_00_0_0_0_0, "illegal_jal"};
      legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001001, 6'b000010};

      // Reset held with lw on c: outputs must be zero before any clock edge
      rst_n = 1'b0;
      c     = 6'b100011;
      #1;
      check("reset_no_edge", 10'b0);
      @(posedge clk);
      #1;
      check("reset_held_edge", 10'b0);
      #2 rst_n = 1'b1;

      // First edge after release registers lw
      step(6'b100011);
      check("first_edge_lw", vecs[1].exp);

      // Decode table
      foreach (vecs[i]) begin
         step(vecs[i].c);
         check(vecs[i].name, vecs[i].exp);
      end

      // Latency: a change of c between edges must not reach the outputs
      step(6'b100011);
      c = 6'b101011;
      #3;
      check("lat_hold_lw", vecs[1].exp);
      @(posedge clk);
      #1;
      check("lat_update_sw", vecs[2].exp);

      // Mid-stream async reset clears without an edge, then release away from an edge
      step(6'b000000);
      #2 rst_n = 1'b0;
      #1;
      check("async_clear", 10'b0);
      c = 6'b100011;
      @(posedge clk);
      #1;
      check("async_held", 10'b0);
      #2 rst_n = 1'b1;
      c = 6'b000100;
      @(posedge clk);
      #1;
      check("post_release_beq", vecs[3].exp);

      // Randomized opcodes against the reference model, plus exclusivity of
      // MemRead/MemWrite/Branch/J
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 6)];
         else                           op = 6'($urandom_range(0, 63));
         step(op);
         check($sformatf("rand_op_%b", op), ref_word(op));
         tests_run++;
         if (!$onehot0({MemRead, MemWrite, Branch, J})) begin
            tests_failed++;
            $display("FAIL excl_%b: got MemRead/MemWrite/Branch/J=%b, required at most one set",
                     op, {MemRead, MemWrite, Branch, J});
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
